// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one synchronous single-port RAM between two requesters:
//     m0 - core memory port (fetch + load/store)
//     m1 - program loader / debug master, able to lock the bus for bursts
//   One transfer is granted per cycle. In the FREE state a lone requester wins
//   and a tie goes to the requester that did not win last. After an m1
//   transfer with m1_lock = 1 only m1 can be granted. The lock ends when m1
//   makes a transfer with m1_lock = 0. A watchdog also breaks the lock once
//   m0 has been kept waiting for MAX_LOCK consecutive cycles, and it then
//   sets the sticky lock_err flag. Read completions are tagged with their
//   owner and return RD_LATENCY cycles after acceptance.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   m0_req/we/be/addr/wdata          m0 request fields (hold until granted)
//   m0_gnt, m0_rvalid, m0_rdata      m0 response
//   m1_req/we/be/addr/wdata, m1_lock m1 request fields + bus lock
//   m1_gnt, m1_rvalid, m1_rdata      m1 response
//   mem_addr/wdata/we/be             RAM command (winner's fields, else 0)
//   mem_rdata                        RAM read data
//   lock_err                         sticky: watchdog broke an m1 lock
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                lock_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    ST_FREE  = 1'b0,
    ST_LOCK1 = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic             last_winner_reg, last_winner_next;  // 1 = m1 won last
  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic             lock_err_reg, lock_err_next;
  logic             gnt0, gnt1;

  // Read-return pipeline: stage 0 is loaded at acceptance, and the last
  // stage drives rvalid.
  logic [RD_LATENCY-1:0] tag_valid_reg;
  logic [RD_LATENCY-1:0] tag_owner_reg;
  logic                  push_valid;
  logic                  push_owner;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_FREE;
      last_winner_reg <= 1'b1;
      wd_cnt_reg      <= '0;
      lock_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_winner_reg <= last_winner_next;
      wd_cnt_reg      <= wd_cnt_next;
      lock_err_reg    <= lock_err_next;
    end
  end

  // ------------------------------------------------------------------
  // Arbitration, lock and watchdog
  // ------------------------------------------------------------------
  always_comb begin
    gnt0             = 1'b0;
    gnt1             = 1'b0;
    state_next       = state_reg;
    last_winner_next = last_winner_reg;
    wd_cnt_next      = wd_cnt_reg;
    lock_err_next    = lock_err_reg;

    // No grant while reset is asserted, so the mem_* outputs read back as
    // idle for the whole reset pulse.
    if (!rst) begin
      case (state_reg)
        ST_FREE: begin
          if (m0_req && m1_req) begin
            gnt0 = last_winner_reg;
            gnt1 = !last_winner_reg;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
          if (gnt1 && m1_lock) begin
            state_next = ST_LOCK1;
          end
          wd_cnt_next = '0;
        end
        ST_LOCK1: begin
          gnt1 = m1_req;
          if (gnt1 && !m1_lock) begin
            // A voluntary release takes priority over the watchdog.
            state_next  = ST_FREE;
            wd_cnt_next = '0;
          end else if (m0_req) begin
            if (wd_cnt_reg == CNT_W'(MAX_LOCK - 1)) begin
              // m0 has now waited MAX_LOCK cycles, so the lock is broken.
              // last_winner = m1 makes m0 win the next tie.
              state_next       = ST_FREE;
              wd_cnt_next      = '0;
              lock_err_next    = 1'b1;
              last_winner_next = 1'b1;
            end else begin
              wd_cnt_next = wd_cnt_reg + 1'b1;
            end
          end else begin
            wd_cnt_next = '0;
          end
        end
        default: state_next = ST_FREE;
      endcase

      if (gnt0) begin
        last_winner_next = 1'b0;
      end
      if (gnt1) begin
        last_winner_next = 1'b1;
      end
    end
  end

  assign m0_gnt   = gnt0;
  assign m1_gnt   = gnt1;
  assign lock_err = lock_err_reg;

  // ------------------------------------------------------------------
  // RAM command mux
  // ------------------------------------------------------------------
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_we;
      mem_be    = m0_be;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
      mem_be    = m1_be;
    end
  end

  // ------------------------------------------------------------------
  // Read-return tag pipeline
  // ------------------------------------------------------------------
  // Writes push an invalid tag, so every stage advances every cycle.
  assign push_valid = (gnt0 && !m0_we) || (gnt1 && !m1_we);
  assign push_owner = gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_reg[0] <= 1'b0;
      tag_owner_reg[0] <= 1'b0;
    end else begin
      tag_valid_reg[0] <= push_valid;
      tag_owner_reg[0] <= push_owner;
    end
  end

  for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_tag_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_valid_reg[gi] <= 1'b0;
        tag_owner_reg[gi] <= 1'b0;
      end else begin
        tag_valid_reg[gi] <= tag_valid_reg[gi-1];
        tag_owner_reg[gi] <= tag_owner_reg[gi-1];
      end
    end
  end

  assign m0_rvalid = tag_valid_reg[RD_LATENCY-1] && !tag_owner_reg[RD_LATENCY-1];
  assign m1_rvalid = tag_valid_reg[RD_LATENCY-1] &&  tag_owner_reg[RD_LATENCY-1];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Two instances (RD_LATENCY 1 and 3, both with
// MAX_LOCK 4) share the same stimulus. A behavioural model tracks the grant,
// the lock and the read completions, which are scheduled by completion cycle.
module tb_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int MAXL  = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [BW-1:0] m0_be, m1_be;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_rdata;

  logic          o_g0 [2];
  logic          o_g1 [2];
  logic          o_rv0 [2];
  logic          o_rv1 [2];
  logic          o_we [2];
  logic          o_err [2];
  logic [BW-1:0] o_be [2];
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_wd [2];
  logic [DW-1:0] o_rd0 [2];
  logic [DW-1:0] o_rd1 [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW),
      .RD_LATENCY(gi == 0 ? LAT_A : LAT_B), .MAX_LOCK(MAXL)
    ) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(o_g0[gi]), .m0_rvalid(o_rv0[gi]), .m0_rdata(o_rd0[gi]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_lock(m1_lock),
      .m1_gnt(o_g1[gi]), .m1_rvalid(o_rv1[gi]), .m1_rdata(o_rd1[gi]),
      .mem_addr(o_addr[gi]), .mem_wdata(o_wd[gi]), .mem_we(o_we[gi]), .mem_be(o_be[gi]),
      .mem_rdata(mem_rdata), .lock_err(o_err[gi])
    );
  end

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  logic       m_locked;
  logic       m_last;       // 1: m1 won the previous transfer
  int         m_wait;       // length of the current run of m0 requests inside a lock
  logic       m_err;
  logic [1:0] sched [2][8]; // per instance, per completion cycle: {valid, owner}
  int         cyc = 0;

  function automatic int lat_of(int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_last   = 1'b1;
    m_wait   = 0;
    m_err    = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) sched[i][k] = 2'b00;
  endtask

  // Returns {m1 granted, m0 granted} for the current inputs.
  function automatic logic [1:0] exp_grant();
    if (rst) return 2'b00;
    if (m_locked) return {m1_req, 1'b0};
    if (m0_req && m1_req) return m_last ? 2'b01 : 2'b10;
    return {m1_req, m0_req};
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d] cyc=%0d got=%0h expected=%0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic [1:0]    g;
    logic [1:0]    s;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    logic [BW-1:0] eb;
    g  = exp_grant();
    ea = '0; ed = '0; ew = 1'b0; eb = '0;
    if (g[0]) begin
      ea = m0_addr; ed = m0_wdata; ew = m0_we; eb = m0_be;
    end else if (g[1]) begin
      ea = m1_addr; ed = m1_wdata; ew = m1_we; eb = m1_be;
    end
    for (int i = 0; i < 2; i++) begin
      s = rst ? 2'b00 : sched[i][cyc % 8];
      chk("gnt0", i, 32'(o_g0[i]), 32'(g[0]));
      chk("gnt1", i, 32'(o_g1[i]), 32'(g[1]));
      chk("mem_addr", i, 32'(o_addr[i]), 32'(ea));
      chk("mem_wdata", i, 32'(o_wd[i]), 32'(ed));
      chk("mem_we", i, 32'(o_we[i]), 32'(ew));
      chk("mem_be", i, 32'(o_be[i]), 32'(eb));
      chk("rvalid0", i, 32'(o_rv0[i]), 32'(s[1] & ~s[0]));
      chk("rvalid1", i, 32'(o_rv1[i]), 32'(s[1] & s[0]));
      chk("lock_err", i, 32'(o_err[i]), 32'(m_err));
      chk("rdata0", i, 32'(o_rd0[i]), 32'(mem_rdata));
      chk("rdata1", i, 32'(o_rd1[i]), 32'(mem_rdata));
    end
  endtask

  task automatic model_update();
    logic [1:0] g;
    if (rst) begin
      model_reset();
      cyc++;
      return;
    end
    g = exp_grant();
    for (int i = 0; i < 2; i++) begin
      sched[i][cyc % 8] = 2'b00;
      if (g[0] && !m0_we) sched[i][(cyc + lat_of(i)) % 8] = 2'b10;
      if (g[1] && !m1_we) sched[i][(cyc + lat_of(i)) % 8] = 2'b11;
    end
    if (g != 2'b00) m_last = g[1];
    if (!m_locked) begin
      if (g[1] && m1_lock) m_locked = 1'b1;
    end else if (g[1] && !m1_lock) begin
      m_locked = 1'b0;
      m_wait   = 0;
    end else if (m0_req) begin
      m_wait++;
      if (m_wait >= MAXL) begin
        m_locked = 1'b0;
        m_wait   = 0;
        m_err    = 1'b1;
        m_last   = 1'b1;
      end
    end else begin
      m_wait = 0;
    end
    if (g[0]) $display("[TX] cyc=%0d m0 %s addr=%h data=%h", cyc, m0_we ? "WR" : "RD", m0_addr, m0_wdata);
    if (g[1]) $display("[TX] cyc=%0d m1 %s addr=%h data=%h lock=%0d", cyc, m1_we ? "WR" : "RD", m1_addr, m1_wdata, m1_lock);
    cyc++;
  endtask

  task automatic half_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic half_update();
    @(posedge clk);
    model_update();
    #1;
    mem_rdata = $urandom;
  endtask

  task automatic step();
    half_check();
    half_update();
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = '0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m1_wdata;
    logic        e_g0, e_g1, e_we, e_rv0, e_rv1;
  } vec_t;

  vec_t vec [11];

  function automatic vec_t mk(logic a, logic b, logic c, logic d, logic e, logic [31:0] w,
                              logic f, logic g, logic h, logic i, logic j);
    vec_t v;
    v.m0_req = a; v.m0_we = b; v.m1_req = c; v.m1_we = d; v.m1_lock = e; v.m1_wdata = w;
    v.e_g0 = f; v.e_g1 = g; v.e_we = h; v.e_rv0 = i; v.e_rv1 = j;
    return v;
  endfunction

  initial begin
    // Expectations below are for the RD_LATENCY = 1 instance, from reset.
    vec[0]  = mk(1, 0, 1, 0, 0, 32'h0,        1, 0, 0, 0, 0); // tie: m0 first
    vec[1]  = mk(1, 0, 1, 0, 0, 32'h0,        0, 1, 0, 1, 0);
    vec[2]  = mk(1, 0, 1, 0, 0, 32'h0,        1, 0, 0, 0, 1);
    vec[3]  = mk(1, 0, 1, 0, 0, 32'h0,        0, 1, 0, 1, 0);
    vec[4]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1);
    vec[5]  = mk(0, 0, 1, 1, 1, 32'hDEADBEEF, 0, 1, 1, 0, 0); // locking write
    vec[6]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0); // m0 blocked
    vec[7]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    vec[8]  = mk(1, 0, 1, 1, 0, 32'h12345678, 0, 1, 1, 0, 0); // releasing write
    vec[9]  = mk(1, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0);
    vec[10] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0);

    idle_inputs();
    mem_rdata = 32'hA5A5_0001;
    model_reset();
    do_reset();

    // Reset state and a single m0 read at 0x10.
    half_check();
    chk("rst_lock_err", 0, 32'(o_err[0]), 32'h0);
    chk("rst_rvalid0", 0, 32'(o_rv0[0]), 32'h0);
    half_update();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_be = 4'hF;
    half_check();
    chk("t1_gnt0", 0, 32'(o_g0[0]), 32'h1);
    chk("t1_mem_addr", 0, o_addr[0], 32'h10);
    chk("t1_mem_we", 0, 32'(o_we[0]), 32'h0);
    half_update();
    idle_inputs();
    half_check();
    chk("t1_rvalid0", 0, 32'(o_rv0[0]), 32'h1);
    chk("t1_rdata0", 0, o_rd0[0], mem_rdata);
    chk("t1_rvalid1", 0, 32'(o_rv1[0]), 32'h0);
    half_update();

    // Round robin and lock/release from the table.
    do_reset();
    for (int v = 0; v < 11; v++) begin
      m0_req = vec[v].m0_req; m0_we = vec[v].m0_we; m0_addr = 32'h20; m0_be = 4'hF;
      m1_req = vec[v].m1_req; m1_we = vec[v].m1_we; m1_lock = vec[v].m1_lock;
      m1_addr = 32'h100; m1_be = 4'hF; m1_wdata = vec[v].m1_wdata;
      half_check();
      chk("tab_gnt0", v, 32'(o_g0[0]), 32'(vec[v].e_g0));
      chk("tab_gnt1", v, 32'(o_g1[0]), 32'(vec[v].e_g1));
      chk("tab_mem_we", v, 32'(o_we[0]), 32'(vec[v].e_we));
      chk("tab_rvalid0", v, 32'(o_rv0[0]), 32'(vec[v].e_rv0));
      chk("tab_rvalid1", v, 32'(o_rv1[0]), 32'(vec[v].e_rv1));
      if (vec[v].e_we) chk("tab_mem_wdata", v, o_wd[0], vec[v].m1_wdata);
      half_update();
    end
    idle_inputs();

    // Watchdog: m1 locks, then idles while m0 waits.
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 32'h200; m1_be = 4'hF;
    half_check();
    chk("wd_lock_gnt1", 0, 32'(o_g1[0]), 32'h1);
    half_update();
    idle_inputs();
    m0_req = 1'b1; m0_addr = 32'h30; m0_be = 4'hF;
    for (int c = 1; c <= MAXL + 1; c++) begin
      half_check();
      chk("wd_gnt0", c, 32'(o_g0[0]), (c == MAXL + 1) ? 32'h1 : 32'h0);
      half_update();
    end
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      half_check();
      chk("wd_lock_err_sticky", c, 32'(o_err[0]), 32'h1);
      half_update();
    end

    // Reset one cycle after an accepted m1 read (lock_err is set here).
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h300; m1_be = 4'hF;
    half_check();
    chk("rst_gnt1", 0, 32'(o_g1[0]), 32'h1);
    half_update();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_gnt", i, 32'({o_g0[i], o_g1[i]}), 32'h0);
      chk("arst_rvalid", i, 32'({o_rv0[i], o_rv1[i]}), 32'h0);
      chk("arst_mem_cmd", i, 32'({o_we[i], o_be[i]}), 32'h0);
      chk("arst_mem_addr", i, o_addr[i], 32'h0);
      chk("arst_mem_wdata", i, o_wd[i], 32'h0);
      chk("arst_lock_err", i, 32'(o_err[i]), 32'h0);
    end
    model_reset();
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      half_check();
      chk("rst_no_rvalid1", 1, 32'(o_rv1[1]), 32'h0);
      half_update();
    end

    // Latency 3: m0 read, m1 write, m1 read on consecutive cycles.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c == 0) begin m0_req = 1'b1; m0_addr = 32'h40; m0_be = 4'hF; end
      if (c == 1) begin m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_be = 4'h3; m1_wdata = 32'h55; end
      if (c == 2) begin m1_req = 1'b1; m1_addr = 32'h48; m1_be = 4'hF; end
      half_check();
      if (c >= 3) begin
        chk("lat3_rvalid0", c, 32'(o_rv0[1]), (c == 3) ? 32'h1 : 32'h0);
        chk("lat3_rvalid1", c, 32'(o_rv1[1]), (c == 5) ? 32'h1 : 32'h0);
      end
      half_update();
    end

    // Randomized traffic against the model.
    idle_inputs();
    for (int n = 0; n < 300; n++) begin
      m0_req   = ($urandom_range(0, 3) != 0);
      m0_we    = $urandom_range(0, 1) == 1;
      m0_be    = BW'($urandom);
      m0_addr  = $urandom;
      m0_wdata = $urandom;
      m1_req   = ($urandom_range(0, 2) != 0);
      m1_we    = $urandom_range(0, 1) == 1;
      m1_be    = BW'($urandom);
      m1_addr  = $urandom;
      m1_wdata = $urandom;
      m1_lock  = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
